div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Iterative multi-cycle controller for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU). These ops cannot be handled by the single-cycle execute-stage ALU.
- Sits beside the ALU in EX and takes the same operands.
- Sequences a 32-step restoring division on an internal subtractor. The subtract carry/borrow convention matches the ALU: A + ~B + 1, with carry-out = no borrow.
- Stalls the pipeline while running and presents a registered result with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand/result width and iteration count. The counter is clog2(WIDTH) bits wide.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
flush  input  1  abort current op (branch mispredict/trap)
op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
a  input  WIDTH  dividend (rs1)
b  input  WIDTH  divisor (rs2)
busy  output  1  high whenever state != IDLE
stall  output  1  pipeline hold request
done  output  1  one-cycle pulse; result valid in this cycle
result  output  WIDTH  registered quotient or remainder

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on reset. Reset has priority over everything.
  - Reset values: state=IDLE, result=0, done=0, busy=0, stall=0, counter=0, all internal registers 0.
  - Reset mid-operation abandons the op; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 and flush=0 in cycle T, latch op, the operand signs, and the operand magnitudes (two's-complement negate when signed and negative; DIVU/REMU use raw values).
  - Divide by zero (b==0) -> DONE at T+1. Result: all-ones for DIV/DIVU; a (unmodified) for REM/REMU.
  - Signed overflow (op=DIV/REM, a=0x80000000, b=0xFFFFFFFF) -> DONE at T+1. Result: 0x80000000 for DIV; 0 for REM.
  - Otherwise -> RUN, counter=0.
- RUN, one iteration per cycle, cycles T+1..T+32:
  - rem' = {rem[WIDTH-2:0], dividend_msb}; dividend shifts left.
  - Trial = rem' - divisor, computed at WIDTH+1 bits.
  - No borrow: rem=trial, quotient bit=1. Borrow: rem=rem', quotient bit=0.
  - After iteration WIDTH-1 (counter wrap), go to DONE.
- Entering DONE, result is registered:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - REM/REMU select the remainder; DIV/DIVU select the quotient.
- DONE (T+33 normal, T+1 special): done=1 for exactly one cycle; next state IDLE.
  - start in the DONE cycle is ignored; the requester re-asserts in IDLE.
- result holds its last value until the next DONE or reset.
- stall:
  - Combinational: (state==IDLE & start & ~flush) | state==RUN.
  - Low in the DONE cycle, so EX captures result on that edge.
- busy = (state != IDLE); it is high during DONE.
- start while busy: ignored, no queueing.
- flush: from any state -> IDLE next cycle.
  - done is suppressed if flush arrives in DONE, and result is not updated.
  - flush together with start in IDLE: flush wins, nothing launches, stall=0.
- Latency: WIDTH+1 cycles start->done for a normal op; 1 cycle for a special case.
- Throughput: one op per WIDTH+2 cycles.

Test Plan:
1. DIVU a=100, b=7, start at T -> stall high T..T+32, done=1 only at T+33, result=14. Repeat with REMU -> result=2.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3) at T+33. REM with the same operands -> 0xFFFFFFFF (-1). REMU 0xFFFFFFF9 / 2 -> 1.
3. Divide by zero: DIV a=5, b=0 -> done at T+1, result=0xFFFFFFFF. REMU a=5, b=0 -> result=5. REM a=0x80000000, b=0 -> result=0x80000000.
4. Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> done at T+1, result=0x80000000. REM -> 0. DIVU with the same operands runs the full 33 cycles -> result=0.
5. Flush and restart: DIVU 9/3 started at T, flush at T+10 -> busy=0 at T+11, no done, result unchanged. Start DIVU 9/3 at T+12 -> done at T+45, result=3. start+flush in the same IDLE cycle -> no launch.
6. Ignored start, reset mid-RUN, done-cycle start:
   - start pulses during RUN are ignored; the original op completes with the correct value.
   - reset at T+5 -> at T+6 busy=0, stall=0, done=0, result=0.
   - start held through the DONE cycle launches only on the following IDLE cycle.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Operand/result bundle between the EX stage and the iterative divider.
// Latency: none, wires only.
// Backpressure: the divider raises stall; EX holds its operands while it is high.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  // EX stage side: issues ops and consumes results.
  modport master (
    output start, flush, op, a, b,
    input  busy, stall, done, result
  );

  // Divider side.
  modport slave (
    input  start, flush, op, a, b,
    output busy, stall, done, result
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU beside the EX-stage ALU.
// Latency: WIDTH+1 cycles start->done; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: stall holds the pipeline while launching/running; starts while busy are dropped.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  div_sequencer_if.slave bus
);
  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH+1:0] ONE_EXT  = (WIDTH+2)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched op context and iteration registers.
  logic [1:0]       op_q;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [CW-1:0]    cnt;
  // stage carries the value shown during DONE; result_q is what is held afterwards.
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] result_q;

  // Launch decode from the live operands.
  logic             launch;
  logic             op_signed;
  logic             op_rem;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] special_val;

  assign launch    = (state == IDLE) & bus.start & ~bus.flush;
  assign op_signed = ~bus.op[0];
  assign op_rem    = bus.op[1];
  assign div_zero  = (bus.b == '0);
  assign ovf       = op_signed & (bus.a == MIN_NEG) & (bus.b == ALL_ONES);
  assign special   = div_zero | ovf;
  assign a_mag     = (op_signed & bus.a[WIDTH-1]) ? (~bus.a + ONE) : bus.a;
  assign b_mag     = (op_signed & bus.b[WIDTH-1]) ? (~bus.b + ONE) : bus.b;
  assign special_val = div_zero ? (op_rem ? bus.a : ALL_ONES)
                                : (op_rem ? '0 : MIN_NEG);

  // One restoring step. The shifted remainder keeps its top bit so divisors
  // above half range still compare correctly; carry-out of A + ~B + 1 = no borrow.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic             trial_unused;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] final_q;
  logic [WIDTH-1:0] final_r;
  logic [WIDTH-1:0] final_val;

  assign rem_sh       = {rem, dividend[WIDTH-1]};
  assign trial        = {1'b0, rem_sh} + {1'b0, ~{1'b0, divisor}} + ONE_EXT;
  assign no_borrow    = trial[WIDTH+1];
  assign trial_unused = trial[WIDTH];
  assign rem_nxt      = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quot_nxt     = {quot[WIDTH-2:0], no_borrow};
  assign q_neg        = ~op_q[0] & (a_neg ^ b_neg);
  assign r_neg        = ~op_q[0] & a_neg;
  assign final_q      = q_neg ? (~quot_nxt + ONE) : quot_nxt;
  assign final_r      = r_neg ? (~rem_nxt + ONE) : rem_nxt;
  assign final_val    = op_q[1] ? final_r : final_q;

  // State register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; flush always returns to IDLE.
  always_comb begin
    state_nxt  = state;
    bus.busy   = (state != IDLE);
    bus.stall  = launch | (state == RUN);
    bus.done   = (state == DONE) & ~bus.flush;
    bus.result = result_q;
    if (bus.done) bus.result = stage;
    case (state)
      IDLE: if (launch) state_nxt = special ? DONE : RUN;
      RUN: begin
        if (bus.flush)        state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on launch, iterate in RUN, commit result when DONE is not flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      stage    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            op_q     <= bus.op;
            a_neg    <= op_signed & bus.a[WIDTH-1];
            b_neg    <= op_signed & bus.b[WIDTH-1];
            dividend <= a_mag;
            divisor  <= b_mag;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            if (special) stage <= special_val;
          end
        end
        RUN: begin
          if (!bus.flush) begin
            dividend <= dividend << 1;
            rem      <= rem_nxt;
            quot     <= quot_nxt;
            cnt      <= cnt + CNT_ONE;
            if (cnt == LAST) stage <= final_val;
          end
        end
        DONE: begin
          if (!bus.flush) result_q <= stage;
        end
        default: ;
      endcase
    end
  end
endmodule
